// File: rtl/multicycle_ctrl.sv
// Control FSM for the multi-cycle MIPS-subset datapath: decodes the opcode once per instruction,
// sequences datapath enables/selects per state, stalls on the memory handshake and aborts on timeout.
module multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TO_W        = 5
) (
    input  logic       clk_i,
    input  logic       rst_n,
    input  logic [5:0] instr_op_i,
    input  logic       mem_ready_i,
    output logic       PCWrite_o,
    output logic       PCWriteCond_o,
    output logic       BranchType_o,
    output logic       IorD_o,
    output logic       MemRead_o,
    output logic       MemWrite_o,
    output logic       IRWrite_o,
    output logic [1:0] RegDst_o,
    output logic [1:0] MemtoReg_o,
    output logic       RegWrite_o,
    output logic       ALUSrcA_o,
    output logic [1:0] ALUSrcB_o,
    output logic [2:0] ALUOp_o,
    output logic [1:0] PCSource_o,
    output logic [3:0] state_o,
    output logic       instr_done_o,
    output logic       illegal_o,
    output logic       mem_err_o
);
    typedef enum logic [3:0] {
        FETCH = 4'd0, DECODE = 4'd1, MEM_ADDR = 4'd2, MEM_RD = 4'd3, MEM_WB = 4'd4,
        MEM_WR = 4'd5, R_EXEC = 4'd6, R_WB = 4'd7, I_EXEC = 4'd8, I_WB = 4'd9,
        BRANCH = 4'd10, JUMP = 4'd11, JAL = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000, OP_ADDI = 6'b010011, OP_LW   = 6'b011000,
                           OP_SW   = 6'b101000, OP_BEQ  = 6'b011001, OP_BNE  = 6'b011010,
                           OP_J    = 6'b001100, OP_JAL  = 6'b001111, OP_BLT  = 6'b011100,
                           OP_BNEZ = 6'b011101, OP_BGEZ = 6'b011110;

    state_t          state, nextState;
    logic [TO_W-1:0] waitCnt;
    logic            waitState, timeout;

    assign waitState = (state == FETCH) || (state == MEM_RD) || (state == MEM_WR);
    // A ready on the would-be timeout cycle completes normally, so timeout requires !mem_ready_i.
    assign timeout   = (MEM_TIMEOUT != 0) && waitState && !mem_ready_i &&
                       (waitCnt == TO_W'(MEM_TIMEOUT));

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= FETCH;
            waitCnt <= '0;
        end else begin
            state <= nextState;
            // FETCH timeout stays in FETCH, so it must clear the counter explicitly
            if (nextState != state || timeout || !waitState)
                waitCnt <= '0;
            else if (!mem_ready_i && waitCnt != '1)
                waitCnt <= waitCnt + 1'b1;
        end
    end

    always_comb begin
        nextState     = state;
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        BranchType_o  = 1'b0;
        IorD_o        = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        IRWrite_o     = 1'b0;
        RegDst_o      = 2'b00;
        MemtoReg_o    = 2'b00;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'b00;
        ALUOp_o       = 3'b000;
        PCSource_o    = 2'b00;
        instr_done_o  = 1'b0;
        illegal_o     = 1'b0;
        mem_err_o     = 1'b0;
        case (state)
            FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'b01;
                // Mealy writes are masked while reset is held so reset outputs stay quiet
                IRWrite_o = mem_ready_i && rst_n;
                PCWrite_o = mem_ready_i && rst_n;
                mem_err_o = timeout;
                if (mem_ready_i) nextState = DECODE;
            end
            DECODE: begin
                ALUSrcB_o = 2'b11;
                case (instr_op_i)
                    OP_LW, OP_SW:                           nextState = MEM_ADDR;
                    OP_R:                                   nextState = R_EXEC;
                    OP_ADDI:                                nextState = I_EXEC;
                    OP_BEQ, OP_BNE, OP_BLT, OP_BNEZ, OP_BGEZ: nextState = BRANCH;
                    OP_J:                                   nextState = JUMP;
                    OP_JAL:                                 nextState = JAL;
                    default: begin
                        illegal_o = 1'b1;
                        nextState = FETCH;
                    end
                endcase
            end
            MEM_ADDR: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                if (instr_op_i == OP_LW)      nextState = MEM_RD;
                else if (instr_op_i == OP_SW) nextState = MEM_WR;
                else                          nextState = FETCH;
            end
            MEM_RD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
                mem_err_o = timeout;
                if (mem_ready_i)  nextState = MEM_WB;
                else if (timeout) nextState = FETCH;
            end
            MEM_WB: begin
                RegWrite_o   = 1'b1;
                MemtoReg_o   = 2'b01;
                instr_done_o = 1'b1;
                nextState    = FETCH;
            end
            MEM_WR: begin
                MemWrite_o   = !timeout;
                IorD_o       = 1'b1;
                mem_err_o    = timeout;
                instr_done_o = mem_ready_i;
                if (mem_ready_i || timeout) nextState = FETCH;
            end
            R_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = 3'b010;
                nextState = R_WB;
            end
            R_WB: begin
                RegWrite_o   = 1'b1;
                RegDst_o     = 2'b01;
                ALUOp_o      = 3'b010;
                instr_done_o = 1'b1;
                nextState    = FETCH;
            end
            I_EXEC: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'b10;
                ALUOp_o   = 3'b011;
                nextState = I_WB;
            end
            I_WB: begin
                RegWrite_o   = 1'b1;
                instr_done_o = 1'b1;
                nextState    = FETCH;
            end
            BRANCH: begin
                ALUSrcA_o     = 1'b1;
                PCWriteCond_o = 1'b1;
                PCSource_o    = 2'b01;
                instr_done_o  = 1'b1;
                nextState     = FETCH;
                case (instr_op_i)
                    OP_BEQ:  ALUOp_o = 3'b001;
                    OP_BNE:  begin ALUOp_o = 3'b110; BranchType_o = 1'b1; end
                    OP_BLT:  begin ALUOp_o = 3'b100; BranchType_o = 1'b1; end
                    OP_BNEZ: ALUOp_o = 3'b110;
                    OP_BGEZ: begin ALUOp_o = 3'b101; BranchType_o = 1'b1; end
                    default: ALUOp_o = 3'b000;
                endcase
            end
            JUMP: begin
                PCWrite_o    = 1'b1;
                PCSource_o   = 2'b10;
                instr_done_o = 1'b1;
                nextState    = FETCH;
            end
            JAL: begin
                PCWrite_o    = 1'b1;
                PCSource_o   = 2'b10;
                RegWrite_o   = 1'b1;
                RegDst_o     = 2'b10;
                MemtoReg_o   = 2'b10;
                instr_done_o = 1'b1;
                nextState    = FETCH;
            end
            default: nextState = FETCH;
        endcase
    end

    assign state_o = state;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: each scenario queues per-cycle stimulus and the full
// expected output vector, then compares the DUT against it cycle by cycle.
module tb_multicycle_ctrl;
    typedef struct packed {
        logic [3:0] st;
        logic       pcW, pcWC, bt, iorD, memRd, memWr, irW;
        logic [1:0] regDst, m2r;
        logic       regW, srcA;
        logic [1:0] srcB;
        logic [2:0] aluOp;
        logic [1:0] pcSrc;
        logic       done, ill, err;
    } outs_t;

    typedef struct packed {
        logic [5:0] op;
        logic       rdy;
    } stim_t;

    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [5:0] instrOp = 6'd0;
    logic       memReady = 1'b1;
    logic       pcW, pcWC, bt, iorD, memRd, memWr, irW, regW, srcA, done, ill, err;
    logic [1:0] regDst, m2r, srcB, pcSrc;
    logic [2:0] aluOp;
    logic [3:0] st;

    int    nTests = 0;
    int    nFail  = 0;
    outs_t expQ[$];
    stim_t stimQ[$];

    multicycle_ctrl #(.MEM_TIMEOUT(4), .TO_W(5)) dut (
        .clk_i(clk), .rst_n(rstN), .instr_op_i(instrOp), .mem_ready_i(memReady),
        .PCWrite_o(pcW), .PCWriteCond_o(pcWC), .BranchType_o(bt), .IorD_o(iorD),
        .MemRead_o(memRd), .MemWrite_o(memWr), .IRWrite_o(irW), .RegDst_o(regDst),
        .MemtoReg_o(m2r), .RegWrite_o(regW), .ALUSrcA_o(srcA), .ALUSrcB_o(srcB),
        .ALUOp_o(aluOp), .PCSource_o(pcSrc), .state_o(st), .instr_done_o(done),
        .illegal_o(ill), .mem_err_o(err)
    );

    always #5 clk = ~clk;

    localparam logic [5:0] R = 6'b000000, ADDI = 6'b010011, LW = 6'b011000, SW = 6'b101000,
                           BEQ = 6'b011001, BNE = 6'b011010, J = 6'b001100, JALOP = 6'b001111,
                           BLT = 6'b011100, BAD = 6'b111111;

    function automatic outs_t mk(input logic [3:0] s, input logic a, b, c, d, e, f, g,
                                 input logic [1:0] rd, mr, input logic rw, sa,
                                 input logic [1:0] sb, input logic [2:0] op, input logic [1:0] ps,
                                 input logic dn, il, er);
        return {s, a, b, c, d, e, f, g, rd, mr, rw, sa, sb, op, ps, dn, il, er};
    endfunction

    function automatic outs_t got();
        return {st, pcW, pcWC, bt, iorD, memRd, memWr, irW, regDst, m2r, regW, srcA, srcB,
                aluOp, pcSrc, done, ill, err};
    endfunction

    // Per-state expected vectors written out as constants
    function automatic outs_t fetchE(input logic r);
        return mk(0, r,0,0,0,1,0,r, 0,0, 0,0, 2'b01, 0, 0, 0,0,0);
    endfunction
    function automatic outs_t decE(input logic il);
        return mk(1, 0,0,0,0,0,0,0, 0,0, 0,0, 2'b11, 0, 0, 0,il,0);
    endfunction
    localparam outs_t MADDR  = {4'd2,  7'b0000000, 2'b00,2'b00, 1'b0,1'b1, 2'b10, 3'b000, 2'b00, 3'b000};
    localparam outs_t MRD    = {4'd3,  7'b0001100, 2'b00,2'b00, 1'b0,1'b0, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam outs_t MWB    = {4'd4,  7'b0000000, 2'b00,2'b01, 1'b1,1'b0, 2'b00, 3'b000, 2'b00, 3'b100};
    localparam outs_t MWRW   = {4'd5,  7'b0001010, 2'b00,2'b00, 1'b0,1'b0, 2'b00, 3'b000, 2'b00, 3'b000};
    localparam outs_t MWRE   = {4'd5,  7'b0001000, 2'b00,2'b00, 1'b0,1'b0, 2'b00, 3'b000, 2'b00, 3'b001};
    localparam outs_t MWRD   = {4'd5,  7'b0001010, 2'b00,2'b00, 1'b0,1'b0, 2'b00, 3'b000, 2'b00, 3'b100};
    localparam outs_t REXEC  = {4'd6,  7'b0000000, 2'b00,2'b00, 1'b0,1'b1, 2'b00, 3'b010, 2'b00, 3'b000};
    localparam outs_t IEXEC  = {4'd8,  7'b0000000, 2'b00,2'b00, 1'b0,1'b1, 2'b10, 3'b011, 2'b00, 3'b000};
    localparam outs_t IWB    = {4'd9,  7'b0000000, 2'b00,2'b00, 1'b1,1'b0, 2'b00, 3'b000, 2'b00, 3'b100};
    localparam outs_t BRBNE  = {4'd10, 7'b0110000, 2'b00,2'b00, 1'b0,1'b1, 2'b00, 3'b110, 2'b01, 3'b100};
    localparam outs_t BRBEQ  = {4'd10, 7'b0100000, 2'b00,2'b00, 1'b0,1'b1, 2'b00, 3'b001, 2'b01, 3'b100};
    localparam outs_t BRBLT  = {4'd10, 7'b0110000, 2'b00,2'b00, 1'b0,1'b1, 2'b00, 3'b100, 2'b01, 3'b100};
    localparam outs_t JMP    = {4'd11, 7'b1000000, 2'b00,2'b00, 1'b0,1'b0, 2'b00, 3'b000, 2'b10, 3'b100};
    localparam outs_t JALE   = {4'd12, 7'b1000000, 2'b10,2'b10, 1'b1,1'b0, 2'b00, 3'b000, 2'b10, 3'b100};
    localparam outs_t FERR   = {4'd0,  7'b0000100, 2'b00,2'b00, 1'b0,1'b0, 2'b01, 3'b000, 2'b00, 3'b001};

    task automatic add(input logic [5:0] op, input logic rdy, input outs_t e);
        stimQ.push_back({op, rdy});
        expQ.push_back(e);
    endtask

    task automatic test_reset();
        outs_t e;
        rstN = 1'b0; memReady = 1'b1; instrOp = ADDI;
        repeat (2) @(negedge clk);
        e = fetchE(1'b0);
        nTests++;
        if (got() !== e) begin
            nFail++;
            $display("FAIL reset: got %h want %h", got(), e);
        end
        @(posedge clk); #1 rstN = 1'b1;
    endtask

    task automatic test_illegal();
        stim_t s; outs_t e; int cyc = 0;
        add(BAD, 1, fetchE(1)); add(BAD, 1, decE(1)); add(BAD, 0, fetchE(0));
        while (expQ.size() > 0) begin
            s = stimQ.pop_front(); instrOp = s.op; memReady = s.rdy;
            @(negedge clk);
            e = expQ.pop_front(); nTests++;
            if (got() !== e) begin
                nFail++;
                $display("FAIL illegal cyc%0d: got %h want %h", cyc, got(), e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_addi();
        stim_t s; outs_t e; int cyc = 0;
        add(ADDI, 1, fetchE(1)); add(ADDI, 1, decE(0)); add(ADDI, 1, IEXEC); add(ADDI, 1, IWB);
        while (expQ.size() > 0) begin
            s = stimQ.pop_front(); instrOp = s.op; memReady = s.rdy;
            @(negedge clk);
            e = expQ.pop_front(); nTests++;
            if (got() !== e) begin
                nFail++;
                $display("FAIL addi cyc%0d: got %h want %h", cyc, got(), e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_wait();
        stim_t s; outs_t e; int cyc = 0;
        add(LW, 1, fetchE(1)); add(LW, 1, decE(0)); add(LW, 1, MADDR);
        for (int i = 0; i < 3; i++) add(LW, 0, MRD);
        add(LW, 1, MRD); add(LW, 1, MWB);
        while (expQ.size() > 0) begin
            s = stimQ.pop_front(); instrOp = s.op; memReady = s.rdy;
            @(negedge clk);
            e = expQ.pop_front(); nTests++;
            if (got() !== e) begin
                nFail++;
                $display("FAIL lw_wait cyc%0d: got %h want %h", cyc, got(), e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        stim_t s; outs_t e; int cyc = 0;
        add(BNE, 1, fetchE(1));   add(BNE, 1, decE(0));   add(BNE, 1, BRBNE);
        add(JALOP, 1, fetchE(1)); add(JALOP, 1, decE(0)); add(JALOP, 1, JALE);
        add(BEQ, 1, fetchE(1));   add(BEQ, 1, decE(0));   add(BEQ, 1, BRBEQ);
        add(BLT, 1, fetchE(1));   add(BLT, 1, decE(0));   add(BLT, 1, BRBLT);
        while (expQ.size() > 0) begin
            s = stimQ.pop_front(); instrOp = s.op; memReady = s.rdy;
            @(negedge clk);
            e = expQ.pop_front(); nTests++;
            if (got() !== e) begin
                nFail++;
                $display("FAIL back_to_back cyc%0d: got %h want %h", cyc, got(), e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_timeout();
        stim_t s; outs_t e; int cyc = 0;
        add(SW, 1, fetchE(1)); add(SW, 1, decE(0)); add(SW, 1, MADDR);
        for (int i = 0; i < 4; i++) add(SW, 0, MWRW);
        add(SW, 0, MWRE);
        // retry: ready arriving on the timeout cycle completes the store
        add(SW, 1, fetchE(1)); add(SW, 1, decE(0)); add(SW, 1, MADDR);
        for (int i = 0; i < 4; i++) add(SW, 0, MWRW);
        add(SW, 1, MWRD);
        while (expQ.size() > 0) begin
            s = stimQ.pop_front(); instrOp = s.op; memReady = s.rdy;
            @(negedge clk);
            e = expQ.pop_front(); nTests++;
            if (got() !== e) begin
                nFail++;
                $display("FAIL sw_timeout cyc%0d: got %h want %h", cyc, got(), e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_timeout();
        stim_t s; outs_t e; int cyc = 0;
        for (int i = 0; i < 4; i++) add(J, 0, fetchE(0));
        add(J, 0, FERR); add(J, 0, fetchE(0));
        add(J, 1, fetchE(1)); add(J, 1, decE(0)); add(J, 1, JMP);
        while (expQ.size() > 0) begin
            s = stimQ.pop_front(); instrOp = s.op; memReady = s.rdy;
            @(negedge clk);
            e = expQ.pop_front(); nTests++;
            if (got() !== e) begin
                nFail++;
                $display("FAIL fetch_timeout cyc%0d: got %h want %h", cyc, got(), e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid();
        stim_t s; outs_t e; int cyc = 0;
        add(R, 1, fetchE(1)); add(R, 1, decE(0)); add(R, 1, REXEC);
        while (expQ.size() > 0) begin
            s = stimQ.pop_front(); instrOp = s.op; memReady = s.rdy;
            @(negedge clk);
            e = expQ.pop_front(); nTests++;
            if (got() !== e) begin
                nFail++;
                $display("FAIL reset_mid cyc%0d: got %h want %h", cyc, got(), e);
            end
            cyc++;
            if (expQ.size() > 0) begin
                @(posedge clk); #1;
            end
        end
        // still inside R_EXEC, away from any clock edge
        #2 rstN = 1'b0;
        expQ.push_back(fetchE(1'b0));
        #1;
        e = expQ.pop_front(); nTests++;
        if (got() !== e) begin
            nFail++;
            $display("FAIL reset_mid async: got %h want %h", got(), e);
        end
        @(posedge clk); #1 rstN = 1'b1;
        add(ADDI, 1, fetchE(1)); add(ADDI, 1, decE(0));
        while (expQ.size() > 0) begin
            s = stimQ.pop_front(); instrOp = s.op; memReady = s.rdy;
            @(negedge clk);
            e = expQ.pop_front(); nTests++;
            if (got() !== e) begin
                nFail++;
                $display("FAIL reset_mid resume cyc%0d: got %h want %h", cyc, got(), e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_illegal();
        test_addi();
        test_lw_wait();
        test_back_to_back();
        test_sw_timeout();
        test_fetch_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end
endmodule
